mmio_port_responder: RTL
========================

// Module: mmio_port_responder
// PURPOSE
//  Memory-mapped I/O responder on the processor data bus (Address/WriteData/MemWrite/MemRead).
//  Answers loads and stores in a 16-byte window, drives PortOut, synchronizes PortIn, and
//  logs every PortIn change into an input FIFO that software drains with loads.
//  Top level muxes ReadData against DataMemory using Hit.
// PARAMETERS
//  BASE_ADDR   32'hFFFF0000  window base; decode Address[31:4]==BASE_ADDR[31:4]
//  FIFO_DEPTH  8             capture FIFO entries; power of 2, 2..16
//  PORT_WIDTH  8             PortIn width, <=8
// PORTS
//  clk        in   1           system clock, rising edge
//  reset      in   1           synchronous, active-high
//  Address    in   32          byte address from processor
//  WriteData  in   32          store data
//  MemWrite   in   1           store strobe, one cycle per sw
//  MemRead    in   1           load strobe, one cycle per lw
//  PortIn     in   PORT_WIDTH  asynchronous external input
//  ReadData   out  32          combinational load data, 0 when !Hit
//  Hit        out  1           combinational, Address inside window
//  PortOut    out  32          registered output port
//  Irq        out  1           only with MMIO_IRQ_EN
// BEHAVIOUR
//  Register map (Address[3:2]; Address[1:0] ignored):
//   0x0 OUT    RW  32-bit, drives PortOut; store updates on the edge, visible next cycle
//   0x4 IN     RO  {zero-pad, sync2}
//   0x8 FIFO   RO  {zero-pad, head entry}; 0 if empty; load pops
//   0xC STATUS RO {23'b0, ovf[8], count[7:3], full[1], empty[0]}; store with bit8=1 clears ovf
//  Stores to IN/FIFO ignored. Access outside window: no side effect, ReadData=0.
//  Reset: PortOut=0, sync1=sync2=prev=0, FIFO empty (count 0), ovf=0, Irq=0.
//   Reset mid-operation discards FIFO contents and pending pushes.
//  Synchronizer: sync1<=PortIn, sync2<=sync1; IN shows new PortIn after 2nd edge.
//  Change detect: push_req = (sync2 != prev); at that edge prev<=sync2 regardless of drop.
//   PortIn change -> FIFO count increments after 3rd edge.
//  Pop: MemRead & Hit & reg==FIFO & !empty, on the edge ending the load cycle;
//   ReadData shows the pre-pop head during the load cycle.
//  Push only: if !full, write tail, count+1; if full, drop and set ovf (sticky).
//  Push+pop same cycle: both occur, count unchanged, no ovf, even when full.
//  Pop when empty: no-op, returns 0. ovf clear and ovf set same cycle: set wins.
//  Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
// CONFIGURATION
//  MMIO_IRQ_EN defined: Irq port exists; Irq <= !empty_next | ovf_next (registered,
//   asserts the edge after first push, deasserts the edge after last pop with ovf=0).
//  MMIO_IRQ_EN undefined: no Irq port, no Irq logic; all else identical.
// TESTING
//  1 reset, sw 0xA5A5A5A5 to 0xFFFF0000 -> PortOut=0xA5A5A5A5 next cycle; lw 0x0 returns it.
//  2 PortIn 0x00->0x3C -> IN=0x3C after 2 edges, STATUS=0x00000008 (count 1) after 3rd;
//    lw 0xFFFF0008 -> 0x3C, then STATUS=0x00000001.
//  3 9 distinct PortIn changes, DEPTH 8, no reads -> STATUS=0x00000142 (ovf, count 8, full);
//    8 pops return first 8 values in order; sw 0x100 to 0xC -> ovf=0.
//  4 FIFO full, PortIn change coincident with pop -> count stays 8, ovf stays 0.
//  5 lw 0xFFFF0008 when empty -> 0, count 0; lw 0x10010000 -> Hit=0, ReadData=0.
//  6 reset asserted with count=5, PortOut!=0 -> next cycle count 0, PortOut 0, Irq 0.

Source files
------------

// File: rtl/mmio_port_responder.sv
// MMIO responder: OUT/IN/FIFO/STATUS window, PortIn synchronizer and change-capture FIFO.
// Define MMIO_IRQ_EN to add the registered Irq output (FIFO non-empty or overflow).
module mmio_port_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF0000,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned PORT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           Address,
    input  logic [31:0]           WriteData,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic [PORT_WIDTH-1:0] PortIn,
    output logic [31:0]           ReadData,
    output logic                  Hit,
    output logic [31:0]           PortOut
`ifdef MMIO_IRQ_EN
    ,
    output logic                  Irq
`endif
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [1:0] RegOut    = 2'd0;
    localparam logic [1:0] RegIn     = 2'd1;
    localparam logic [1:0] RegFifo   = 2'd2;
    localparam logic [1:0] RegStatus = 2'd3;

    logic [31:0]           out_q, out_d;
    logic [PORT_WIDTH-1:0] sync1_q, sync2_q, prev_q;
    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic [PORT_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PORT_WIDTH-1:0] mem_d [FIFO_DEPTH];

    logic [1:0]            reg_sel;
    logic                  wr_en, rd_en;
    logic                  empty, full;
    logic                  push_req, push_ok, pop, ovf_set, ovf_clr;
    logic [31:0]           status;
    logic                  unused_addr;

    assign unused_addr = ^Address[1:0];

    assign reg_sel  = Address[3:2];
    assign Hit      = (Address[31:4] == BASE_ADDR[31:4]);
    assign wr_en    = MemWrite & Hit;
    assign rd_en    = MemRead & Hit;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign push_req = (sync2_q != prev_q);
    assign pop      = rd_en && (reg_sel == RegFifo) && !empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO is still accepted.
    assign push_ok  = push_req && (!full || pop);
    assign ovf_set  = push_req && !push_ok;
    assign ovf_clr  = wr_en && (reg_sel == RegStatus) && WriteData[8];

    always_comb begin
        out_d = out_q;
        if (wr_en && (reg_sel == RegOut)) begin
            out_d = WriteData;
        end
    end

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_ok) begin
            mem_d[tail_q] = sync2_q;
            tail_d        = tail_q + PW'(1);
        end
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Set wins over a same-cycle clear.
        ovf_d = ovf_set | (ovf_q & ~ovf_clr);
    end

    always_comb begin
        status      = 32'h0;
        status[8]   = ovf_q;
        status[7:3] = 5'(count_q);
        status[1]   = full;
        status[0]   = empty;
    end

    always_comb begin
        ReadData = 32'h0;
        if (Hit) begin
            case (reg_sel)
                RegOut:    ReadData = out_q;
                RegIn:     ReadData = {{(32-PORT_WIDTH){1'b0}}, sync2_q};
                RegFifo:   ReadData = empty ? 32'h0
                                            : {{(32-PORT_WIDTH){1'b0}}, mem_q[head_q]};
                RegStatus: ReadData = status;
                default:   ReadData = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q   <= 32'h0;
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            mem_q   <= '{default: '0};
        end else begin
            out_q   <= out_d;
            sync1_q <= PortIn;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            mem_q   <= mem_d;
        end
    end

    assign PortOut = out_q;

`ifdef MMIO_IRQ_EN
    logic irq_q, irq_d;

    assign irq_d = (count_d != '0) | ovf_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign Irq = irq_q;
`endif

endmodule
